// File: rtl/commit_unit_pkg.sv
// commit_unit_pkg: LC-3b opcode/reg types, commit FSM states and CC helpers
package commit_unit_pkg;
   typedef enum logic [3:0] {
      op_br  = 4'b0000, op_add = 4'b0001, op_ldb = 4'b0010, op_stb = 4'b0011,
      op_jsr = 4'b0100, op_and = 4'b0101, op_ldr = 4'b0110, op_str = 4'b0111,
      op_rti = 4'b1000, op_not = 4'b1001, op_ldi = 4'b1010, op_sti = 4'b1011,
      op_jmp = 4'b1100, op_shf = 4'b1101, op_lea = 4'b1110, op_trap = 4'b1111
   } lc3b_opcode;
   typedef logic [2:0] lc3b_reg;
   typedef enum logic [1:0] {COMMIT, STORE, FLUSH} commit_state_t;
   localparam logic [2:0] CC_RESET = 3'b010;
   // nzp from the sign bit and an all-zero flag, so it works for any word width
   function automatic logic [2:0] gencc(input logic neg, input logic zero);
      return {neg, zero, ~neg & ~zero};
   endfunction
   function automatic logic cccomp(input logic [2:0] cc, input logic [2:0] nzp);
      return |(cc & nzp);
   endfunction
   function automatic logic is_writer(input lc3b_opcode op);
      return op inside {op_add, op_and, op_not, op_shf, op_lea, op_ldr};
   endfunction
endpackage

// File: rtl/commit_unit_cc_chain.sv
// commit_cc_chain: per-slot CC forward chain and branch-enable evaluation
module commit_cc_chain
   import commit_unit_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int COMMIT_WIDTH = 2
) (
   input  logic [2:0]                         i_cc,
   input  logic [4*COMMIT_WIDTH-1:0]          i_opcode,
   input  logic [3*COMMIT_WIDTH-1:0]          i_dest,
   input  logic [DATA_WIDTH*COMMIT_WIDTH-1:0] i_value,
   output logic [3*(COMMIT_WIDTH+1)-1:0]      o_cc_chain,
   output logic [COMMIT_WIDTH-1:0]            o_br_en
);
   logic [2:0]            w_cc [COMMIT_WIDTH+1];
   logic [DATA_WIDTH-1:0] w_val;
   // w_cc[i] is the CC seen by slot i; writers replace it for every younger slot
   always_comb begin
      w_cc[0] = i_cc;
      o_br_en = '0;
      w_val   = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         w_val       = i_value[DATA_WIDTH*i +: DATA_WIDTH];
         o_br_en[i]  = cccomp(w_cc[i], i_dest[3*i +: 3]);
         w_cc[i+1]   = is_writer(lc3b_opcode'(i_opcode[4*i +: 4])) ? gencc(w_val[DATA_WIDTH-1], ~|w_val) : w_cc[i];
      end
   end
   // flatten the chain for the parent
   always_comb begin
      o_cc_chain = '0;
      for (int i = 0; i <= COMMIT_WIDTH; i++) o_cc_chain[3*i +: 3] = w_cc[i];
   end
endmodule

// File: rtl/commit_unit.sv
// commit_unit: in-order multi-slot retire stage; COMMIT_PERF_EN adds perf counters
module commit_unit
   import commit_unit_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int TAG_WIDTH    = 3,
   parameter int COMMIT_WIDTH = 2,
   localparam int CW          = $clog2(COMMIT_WIDTH + 1)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [COMMIT_WIDTH-1:0]            i_rob_valid,
   input  logic [4*COMMIT_WIDTH-1:0]          i_rob_opcode,
   input  logic [3*COMMIT_WIDTH-1:0]          i_rob_dest,
   input  logic [DATA_WIDTH*COMMIT_WIDTH-1:0] i_rob_value,
   input  logic [COMMIT_WIDTH-1:0]            i_rob_predict,
   input  logic [TAG_WIDTH*COMMIT_WIDTH-1:0]  i_rob_tag,
   output logic [CW-1:0]                      o_re_count,
   output logic [COMMIT_WIDTH-1:0]            o_rf_we,
   output logic [3*COMMIT_WIDTH-1:0]          o_rf_dest,
   output logic [DATA_WIDTH*COMMIT_WIDTH-1:0] o_rf_value,
   output logic [TAG_WIDTH*COMMIT_WIDTH-1:0]  o_rf_tag,
   output logic                               o_flush,
   output logic                               o_pcmux_sel,
   output logic [DATA_WIDTH-1:0]              o_new_pc,
   output logic                               o_dmem_write,
   input  logic                               i_dmem_resp,
   output logic [2:0]                         o_cc_out
`ifdef COMMIT_PERF_EN
  ,output logic [31:0]                        o_perf_retired,
   output logic [31:0]                        o_perf_mispredict,
   output logic [31:0]                        o_perf_store_stall
`endif
);
   commit_state_t                    r_state, w_next;
   logic [2:0]                       r_cc, w_cc_next;
   logic [DATA_WIDTH-1:0]            r_new_pc, w_new_pc;
   logic [CW-1:0]                    w_cnt, w_re_count;
   logic [COMMIT_WIDTH-1:0]          w_we_raw, w_rf_we, w_br_en;
   logic [3*(COMMIT_WIDTH+1)-1:0]    w_cc_chain;
   logic                             w_stop;
   lc3b_opcode                       w_op [COMMIT_WIDTH];

   commit_cc_chain #(.DATA_WIDTH(DATA_WIDTH), .COMMIT_WIDTH(COMMIT_WIDTH)) u_cc_chain (
      .i_cc       (r_cc),
      .i_opcode   (i_rob_opcode),
      .i_dest     (i_rob_dest),
      .i_value    (i_rob_value),
      .o_cc_chain (w_cc_chain),
      .o_br_en    (w_br_en)
   );

   // decode opcode fields per slot
   always_comb begin
      for (int i = 0; i < COMMIT_WIDTH; i++) w_op[i] = lc3b_opcode'(i_rob_opcode[4*i +: 4]);
   end

   // next state and retire scan: stop at the first invalid slot, store or mispredict
   always_comb begin
      w_next   = r_state;
      w_cnt    = '0;
      w_we_raw = '0;
      w_new_pc = r_new_pc;
      w_stop   = 1'b0;
      case (r_state)
         STORE: w_next = i_dmem_resp ? COMMIT : STORE;
         FLUSH: w_next = COMMIT;
         default: begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
               if (!w_stop) begin
                  if (!i_rob_valid[i] || w_op[i] == op_str) begin
                     w_stop = 1'b1;
                     if (i == 0 && i_rob_valid[0]) w_next = STORE;
                  end else begin
                     w_cnt       = w_cnt + CW'(1);
                     w_we_raw[i] = is_writer(w_op[i]);
                     if (w_op[i] == op_br && w_br_en[i] != i_rob_predict[i]) begin
                        w_stop   = 1'b1;
                        w_next   = FLUSH;
                        w_new_pc = i_rob_value[DATA_WIDTH*i +: DATA_WIDTH];
                     end
                  end
               end
            end
         end
      endcase
      w_re_count = (r_state == STORE) ? CW'(i_dmem_resp) : w_cnt;
      w_cc_next  = (r_state == COMMIT) ? w_cc_chain[3*w_cnt +: 3] : r_cc;
   end

   // only the youngest retiring writer of a destination gets the regfile write
   always_comb begin
      w_rf_we = w_we_raw;
      for (int i = 0; i < COMMIT_WIDTH; i++)
         for (int j = i + 1; j < COMMIT_WIDTH; j++)
            if (w_we_raw[j] && i_rob_dest[3*j +: 3] == i_rob_dest[3*i +: 3]) w_rf_we[i] = 1'b0;
   end

   // state, architectural CC and redirect target
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= COMMIT;
         r_cc     <= CC_RESET;
         r_new_pc <= '0;
      end else begin
         r_state  <= w_next;
         r_cc     <= w_cc_next;
         r_new_pc <= w_new_pc;
      end
   end

   assign o_re_count   = rst_n ? w_re_count : '0;
   assign o_rf_we      = rst_n ? w_rf_we : '0;
   assign o_rf_dest    = rst_n ? i_rob_dest : '0;
   assign o_rf_value   = rst_n ? i_rob_value : '0;
   assign o_rf_tag     = rst_n ? i_rob_tag : '0;
   assign o_flush      = r_state == FLUSH;
   assign o_pcmux_sel  = r_state == FLUSH;
   assign o_new_pc     = r_new_pc;
   assign o_dmem_write = r_state == STORE;
   assign o_cc_out     = r_cc;

`ifdef COMMIT_PERF_EN
   logic [31:0] r_perf_retired, r_perf_mispredict, r_perf_store_stall;
   logic [32:0] w_ret_sum;
   assign w_ret_sum = {1'b0, r_perf_retired} + 33'(w_re_count);
   // saturating event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_retired     <= '0;
         r_perf_mispredict  <= '0;
         r_perf_store_stall <= '0;
      end else begin
         r_perf_retired     <= w_ret_sum[32] ? '1 : w_ret_sum[31:0];
         r_perf_mispredict  <= r_perf_mispredict + 32'((r_state == FLUSH) && ~&r_perf_mispredict);
         r_perf_store_stall <= r_perf_store_stall + 32'((r_state == STORE) && !i_dmem_resp && ~&r_perf_store_stall);
      end
   end
   assign o_perf_retired     = r_perf_retired;
   assign o_perf_mispredict  = r_perf_mispredict;
   assign o_perf_store_stall = r_perf_store_stall;
`endif
endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: directed vector table plus store/flush/reset sequences for commit_unit (W=2)
module tb_commit_unit;
   localparam logic [3:0] OP_BR = 4'd0, OP_ADD = 4'd1, OP_AND = 4'd5, OP_STR = 4'd7,
                          OP_NOT = 4'd9, OP_JMP = 4'd12, OP_LEA = 4'd14;
   localparam int NV = 14;

   typedef struct {
      logic [1:0]  v;
      logic [3:0]  op0, op1;
      logic [2:0]  d0, d1;
      logic [15:0] x0, x1;
      logic [1:0]  p;
      logic [1:0]  e_re;
      logic [1:0]  e_we;
      logic [2:0]  e_cc;
      logic        e_fl;
      logic [15:0] e_pc;
      logic        e_st;
   } vec_t;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [1:0]  rob_valid, rob_predict, re_count, rf_we;
   logic [7:0]  rob_opcode;
   logic [5:0]  rob_dest, rob_tag, rf_dest, rf_tag;
   logic [31:0] rob_value, rf_value;
   logic        flush, pcmux_sel, dmem_write, dmem_resp;
   logic [15:0] new_pc;
   logic [2:0]  cc_out;
   int          n_chk = 0, n_err = 0;
   vec_t        tab [NV];

   always #5 clk = ~clk;

   commit_unit dut (
      .clk(clk), .rst_n(rst_n),
      .i_rob_valid(rob_valid), .i_rob_opcode(rob_opcode), .i_rob_dest(rob_dest),
      .i_rob_value(rob_value), .i_rob_predict(rob_predict), .i_rob_tag(rob_tag),
      .o_re_count(re_count), .o_rf_we(rf_we), .o_rf_dest(rf_dest), .o_rf_value(rf_value),
      .o_rf_tag(rf_tag), .o_flush(flush), .o_pcmux_sel(pcmux_sel), .o_new_pc(new_pc),
      .o_dmem_write(dmem_write), .i_dmem_resp(dmem_resp), .o_cc_out(cc_out)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      rob_valid   = t.v;
      rob_opcode  = {t.op1, t.op0};
      rob_dest    = {t.d1, t.d0};
      rob_value   = {t.x1, t.x0};
      rob_predict = t.p;
      rob_tag     = {3'd1, 3'd0};
   endtask

   task automatic idle();
      rob_valid = '0; rob_opcode = '0; rob_dest = '0; rob_value = '0; rob_predict = '0; rob_tag = '0; dmem_resp = 1'b0;
   endtask

   task automatic fresh_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle();
      #1 rst_n = 1'b1;
   endtask

   initial begin
      //         v      op0     op1     d0    d1      x0        x1       p     re  we     cc     fl  pc        st
      tab[0]  = '{2'b11, OP_ADD, OP_BR,  3'd1, 3'b100, 16'd5,    16'h0,   2'b00, 2, 2'b01, 3'b001, 0, 16'h0,    0};
      tab[1]  = '{2'b11, OP_ADD, OP_BR,  3'd1, 3'b100, 16'hFFFF, 16'h0040,2'b00, 2, 2'b01, 3'b100, 1, 16'h0040, 0};
      tab[2]  = '{2'b11, OP_ADD, OP_ADD, 3'd2, 3'd2,   16'd1,    16'd7,   2'b00, 2, 2'b10, 3'b001, 0, 16'h0,    0};
      tab[3]  = '{2'b01, OP_ADD, OP_ADD, 3'd3, 3'd4,   16'd0,    16'd9,   2'b00, 1, 2'b01, 3'b010, 0, 16'h0,    0};
      tab[4]  = '{2'b00, OP_ADD, OP_ADD, 3'd3, 3'd4,   16'd9,    16'd9,   2'b00, 0, 2'b00, 3'b010, 0, 16'h0,    0};
      tab[5]  = '{2'b10, OP_ADD, OP_ADD, 3'd3, 3'd4,   16'd9,    16'hFFF0,2'b00, 0, 2'b00, 3'b010, 0, 16'h0,    0};
      tab[6]  = '{2'b11, OP_STR, OP_ADD, 3'd1, 3'd4,   16'h100,  16'd3,   2'b00, 0, 2'b00, 3'b010, 0, 16'h0,    1};
      tab[7]  = '{2'b11, OP_ADD, OP_STR, 3'd1, 3'd4,   16'd5,    16'd3,   2'b00, 1, 2'b01, 3'b001, 0, 16'h0,    0};
      tab[8]  = '{2'b11, OP_BR,  OP_NOT, 3'b010,3'd4,  16'h2000, 16'h8000,2'b01, 2, 2'b10, 3'b100, 0, 16'h0,    0};
      tab[9]  = '{2'b11, OP_BR,  OP_ADD, 3'b001,3'd4,  16'h1234, 16'd3,   2'b01, 1, 2'b00, 3'b010, 1, 16'h1234, 0};
      tab[10] = '{2'b11, OP_JMP, OP_AND, 3'd0, 3'd5,   16'hFFFF, 16'd3,   2'b00, 2, 2'b10, 3'b001, 0, 16'h0,    0};
      tab[11] = '{2'b11, OP_ADD, OP_ADD, 3'd1, 3'd2,   16'h8000, 16'd0,   2'b00, 2, 2'b11, 3'b010, 0, 16'h0,    0};
      tab[12] = '{2'b11, OP_LEA, OP_BR,  3'd1, 3'b111, 16'd0,    16'h00AA,2'b00, 2, 2'b01, 3'b010, 1, 16'h00AA, 0};
      tab[13] = '{2'b11, OP_BR,  OP_ADD, 3'b101,3'd6,  16'h0300, 16'hFFFE,2'b00, 2, 2'b10, 3'b100, 0, 16'h0,    0};

      // reset state, with a valid group presented during reset
      idle();
      drive(tab[0]);
      #12;
      chk("rst_re_count", 32'(re_count), 32'd0);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_pcmux", 32'(pcmux_sel), 32'd0);
      chk("rst_dmem_write", 32'(dmem_write), 32'd0);
      chk("rst_new_pc", 32'(new_pc), 32'd0);
      chk("rst_cc", 32'(cc_out), 32'h2);

      // table: each vector starts from a fresh reset (cc = 010)
      for (int i = 0; i < NV; i++) begin
         fresh_reset();
         drive(tab[i]);
         #1;
         chk($sformatf("v%0d_re_count", i), 32'(re_count), 32'(tab[i].e_re));
         chk($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(tab[i].e_we));
         @(posedge clk); #1;
         chk($sformatf("v%0d_cc", i), 32'(cc_out), 32'(tab[i].e_cc));
         chk($sformatf("v%0d_flush", i), 32'(flush), 32'(tab[i].e_fl));
         chk($sformatf("v%0d_pcmux", i), 32'(pcmux_sel), 32'(tab[i].e_fl));
         chk($sformatf("v%0d_dmem_write", i), 32'(dmem_write), 32'(tab[i].e_st));
         if (tab[i].e_fl) chk($sformatf("v%0d_new_pc", i), 32'(new_pc), 32'(tab[i].e_pc));
      end

      // same-dest group: younger value passes through on slot 1
      fresh_reset();
      drive(tab[2]);
      #1 chk("samedest_rf_value1", 32'(rf_value[31:16]), 32'd7);
      chk("samedest_rf_dest1", 32'(rf_dest[5:3]), 32'd2);

      // mispredict: flush only in N+1, no retire during it, gone in N+2
      fresh_reset();
      drive(tab[1]);
      @(posedge clk); #1;
      chk("flush_n1_re_count", 32'(re_count), 32'd0);
      chk("flush_n1_rf_we", 32'(rf_we), 32'd0);
      chk("flush_n1_flush", 32'(flush), 32'd1);
      idle();
      @(posedge clk); #1;
      chk("flush_n2_flush", 32'(flush), 32'd0);
      chk("flush_n2_pcmux", 32'(pcmux_sel), 32'd0);

      // store with dmem_resp low for 3 cycles, resp ignored while in COMMIT
      fresh_reset();
      dmem_resp = 1'b1;
      #1 chk("resp_in_commit_re_count", 32'(re_count), 32'd0);
      dmem_resp = 1'b0;
      drive(tab[6]);
      #1 chk("st_n_re_count", 32'(re_count), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk($sformatf("st_wait%0d_dmem_write", k), 32'(dmem_write), 32'd1);
         chk($sformatf("st_wait%0d_re_count", k), 32'(re_count), 32'd0);
      end
      @(posedge clk); #1;
      dmem_resp = 1'b1;
      #1;
      chk("st_resp_dmem_write", 32'(dmem_write), 32'd1);
      chk("st_resp_re_count", 32'(re_count), 32'd1);
      @(posedge clk); #1;
      idle();
      #1;
      chk("st_after_dmem_write", 32'(dmem_write), 32'd0);
      chk("st_after_re_count", 32'(re_count), 32'd0);

      // add then store behind it; store moves to slot 0; reset mid-STORE
      fresh_reset();
      drive(tab[7]);
      #1 chk("st2_re_count", 32'(re_count), 32'd1);
      @(posedge clk); #1;
      chk("st2_cc", 32'(cc_out), 32'h1);
      chk("st2_dmem_write_early", 32'(dmem_write), 32'd0);
      rob_valid = 2'b01; rob_opcode = {OP_ADD, OP_STR};
      @(posedge clk); #1;
      chk("st2_dmem_write", 32'(dmem_write), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("st2_rst_dmem_write", 32'(dmem_write), 32'd0);
      chk("st2_rst_cc", 32'(cc_out), 32'h2);
      chk("st2_rst_re_count", 32'(re_count), 32'd0);

      // reset asserted mid-FLUSH
      fresh_reset();
      drive(tab[9]);
      @(posedge clk); #1;
      chk("fl_rst_pre_flush", 32'(flush), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("fl_rst_flush", 32'(flush), 32'd0);
      chk("fl_rst_pcmux", 32'(pcmux_sel), 32'd0);
      chk("fl_rst_new_pc", 32'(new_pc), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule
